// File: rtl/frame_draw_sequencer_pkg.sv
// Shared definitions for the snake playfield redraw path:
// cell indices, sequencer state encoding and the logb2 helper.
package snake_pkg;

  localparam logic [1:0] BG    = 2'd0;
  localparam logic [1:0] SNAKE = 2'd1;
  localparam logic [1:0] COIN  = 2'd2;
  localparam logic [1:0] HEAD  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_BODY_REQ,
    S_BODY,
    S_COIN,
    S_HEAD,
    S_DONE
  } state_e;

  // ceil(log2(n)): bits needed to index n items
  function automatic int logb2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((32'sd1 <<< i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/frame_draw_sequencer_if.sv
// Bundle between the redraw sequencer, its body/coin/head sources
// and the screen-memory write port.
interface frame_draw_sequencer_if #(
  parameter int XB = 5,
  parameter int YB = 5,
  parameter int AB = 10
);

  logic          tick;
  logic          body_shift;
  logic          body_valid;
  logic [XB-1:0] body_x;
  logic [YB-1:0] body_y;
  logic          body_end;
  logic          coin_exists;
  logic [XB-1:0] coin_x;
  logic [YB-1:0] coin_y;
  logic [XB-1:0] head_x;
  logic [YB-1:0] head_y;
  logic          mem_we;
  logic [AB-1:0] mem_addr;
  logic [1:0]    mem_data;
  logic          busy;
  logic          frame_done;
  logic          wd_error;

  modport master (
    input  tick, body_valid, body_x, body_y,
    input  body_end, coin_exists, coin_x, coin_y,
    input  head_x, head_y,
    output body_shift, mem_we, mem_addr, mem_data,
    output busy, frame_done, wd_error
  );

  modport slave (
    output tick, body_valid, body_x, body_y,
    output body_end, coin_exists, coin_x, coin_y,
    output head_x, head_y,
    input  body_shift, mem_we, mem_addr, mem_data,
    input  busy, frame_done, wd_error
  );

endinterface

// File: rtl/frame_draw_sequencer_counter.sv
// Free-running 0..MAX counter; ovf_o marks the enabled MAX cycle
// and the count wraps to 0 on it.
module StaticCounter
  import snake_pkg::*;
#(
  parameter int MAX = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en_i,
  output logic [logb2(MAX+1)-1:0]   count_o,
  output logic                      ovf_o
);

  localparam int W = logb2(MAX + 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign ovf_o   = en_i && (count_q == W'(MAX));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (ovf_o)     count_d = '0;
    else if (en_i) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/frame_draw_sequencer.sv
// Redraw pass owner of screen port A: clear, body, coin, head.
// FRAME_OVERRUN_COUNT_EN adds the saturating overrun_count output.
module frame_draw_sequencer
  import snake_pkg::*;
#(
  parameter int H         = 32,
  parameter int V         = 32,
  parameter int WD_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  frame_draw_sequencer_if.master bus
`ifdef FRAME_OVERRUN_COUNT_EN
  , output logic [7:0] overrun_count
`endif
);

  localparam int XB  = logb2(H);
  localparam int YB  = logb2(V);
  localparam int AB  = logb2(H * V);
  localparam int WD  = (WD_CYCLES == 0) ? H * V + 4 : WD_CYCLES;
  localparam int WDW = logb2(WD + 1);

  state_e state_q, state_d;
  logic   pend_q, pend_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic   wderr_q, wderr_d;
  logic   we_q, we_d;
  logic [AB-1:0] addr_q, addr_d;
  logic [1:0] data_q, data_d;
  logic   busy_q, shift_q, done_q;

  logic          clr_en;
  logic          clr_ovf;
  logic [AB-1:0] clr_cnt;

  function automatic logic [AB-1:0] cell_addr(
    input logic [XB-1:0] x,
    input logic [YB-1:0] y
  );
    return AB'(32'(y) * 32'(H) + 32'(x));
  endfunction

  assign clr_en = (state_q == S_CLEAR);

  StaticCounter #(.MAX(H * V - 1)) u_clr (
    .clk     (clk),
    .reset   (reset),
    .en_i    (clr_en),
    .count_o (clr_cnt),
    .ovf_o   (clr_ovf)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    wd_d    = '0;
    wderr_d = wderr_q;
    we_d    = 1'b0;
    addr_d  = '0;
    data_d  = BG;
    if (bus.tick && state_q != S_IDLE) pend_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (bus.tick) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        we_d   = 1'b1;
        addr_d = clr_cnt;
        if (clr_ovf) state_d = S_BODY_REQ;
      end
      S_BODY_REQ: state_d = S_BODY;
      S_BODY: begin
        wd_d = wd_q + WDW'(1);
        if (bus.body_valid) begin
          we_d   = 1'b1;
          addr_d = cell_addr(bus.body_x, bus.body_y);
          data_d = SNAKE;
        end
        if (bus.body_end) begin
          state_d = S_COIN;
        end else if (wd_q == WDW'(WD - 1)) begin
          wderr_d = 1'b1;
          state_d = S_COIN;
        end
      end
      S_COIN: begin
        we_d    = bus.coin_exists;
        addr_d  = cell_addr(bus.coin_x, bus.coin_y);
        data_d  = COIN;
        state_d = S_HEAD;
      end
      S_HEAD: begin
        we_d    = 1'b1;
        addr_d  = cell_addr(bus.head_x, bus.head_y);
        data_d  = HEAD;
        state_d = S_DONE;
      end
      S_DONE: begin
        // a tick landing in DONE itself chains straight into the next pass
        if (pend_q || bus.tick) begin
          state_d = S_CLEAR;
          pend_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      wd_q    <= '0;
      wderr_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= BG;
      busy_q  <= 1'b0;
      shift_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      wd_q    <= wd_d;
      wderr_q <= wderr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= (state_d != S_IDLE);
      shift_q <= (state_q == S_BODY_REQ);
      done_q  <= (state_q == S_DONE);
    end
  end

  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_data   = data_q;
  assign bus.busy       = busy_q;
  assign bus.body_shift = shift_q;
  assign bus.frame_done = done_q;
  assign bus.wd_error   = wderr_q;

`ifdef FRAME_OVERRUN_COUNT_EN
  logic [7:0] ovc_q;

  always_ff @(posedge clk) begin
    if (!reset)
      ovc_q <= '0;
    else if (bus.tick && pend_q && ovc_q != 8'hFF)
      ovc_q <= ovc_q + 8'd1;
  end

  assign overrun_count = ovc_q;
`endif

endmodule
